// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - Simon message codes, 7-segment glyphs and glyph-index helpers
package simon_pkg;

    localparam logic [3:0] MSG_RED   = 4'd0;
    localparam logic [3:0] MSG_GREEN = 4'd1;
    localparam logic [3:0] MSG_BLUE  = 4'd2;
    localparam logic [3:0] MSG_YEL   = 4'd3;
    localparam logic [3:0] MSG_RDY   = 4'd4;
    localparam logic [3:0] MSG_GOOD  = 4'd5;
    localparam logic [3:0] MSG_ERR   = 4'd6;
    localparam logic [3:0] MSG_DONE  = 4'd7;
    localparam logic [3:0] MSG_SCORE = 4'd8;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_P     = 7'h0C;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_G     = 7'h42;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_L     = 7'h47;
    localparam logic [6:0] SEG_U     = 7'h63;
    localparam logic [6:0] SEG_Y     = 7'h11;
    localparam logic [6:0] SEG_O     = 7'h23;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Decimal digits occupy indices 0..9 so a BCD nibble maps straight across
    typedef enum logic [4:0] {
        GL_0 = 5'd0, GL_1, GL_2, GL_3, GL_4, GL_5, GL_6, GL_7, GL_8, GL_9,
        GL_P, GL_DASH, GL_R, GL_E, GL_D, GL_G, GL_N, GL_B, GL_L, GL_U,
        GL_Y, GL_O, GL_BLANK
    } glyph_e;

    function automatic glyph_e digit_glyph(input logic [3:0] nib);
        return (nib <= 4'd9) ? glyph_e'({1'b0, nib}) : GL_DASH;
    endfunction

    function automatic logic [6:0] glyph_seg(input glyph_e g);
        case (g)
            GL_0:    return SEG_0;
            GL_1:    return SEG_1;
            GL_2:    return SEG_2;
            GL_3:    return SEG_3;
            GL_4:    return SEG_4;
            GL_5:    return SEG_5;
            GL_6:    return SEG_6;
            GL_7:    return SEG_7;
            GL_8:    return SEG_8;
            GL_9:    return SEG_9;
            GL_P:    return SEG_P;
            GL_DASH: return SEG_DASH;
            GL_R:    return SEG_R;
            GL_E:    return SEG_E;
            GL_D:    return SEG_D;
            GL_G:    return SEG_G;
            GL_N:    return SEG_N;
            GL_B:    return SEG_B;
            GL_L:    return SEG_L;
            GL_U:    return SEG_U;
            GL_Y:    return SEG_Y;
            GL_O:    return SEG_O;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 8-bit double-dabble converter with start/busy/done handshake
module bin2bcd_seq
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    typedef enum logic [1:0] {C_IDLE, C_SHIFT, C_COMMIT} conv_state_e;

    conv_state_e state;
    logic [19:0] sr;
    logic [19:0] adj;
    logic [2:0]  shift_cnt;

    always_comb begin
        adj = sr;
        if (sr[11:8]  >= 4'd5) adj[11:8]  = sr[11:8]  + 4'd3;
        if (sr[15:12] >= 4'd5) adj[15:12] = sr[15:12] + 4'd3;
        if (sr[19:16] >= 4'd5) adj[19:16] = sr[19:16] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= C_IDLE;
            sr        <= '0;
            shift_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                C_IDLE: begin
                    if (start) begin
                        sr        <= {12'd0, bin};
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= C_SHIFT;
                    end
                end
                C_SHIFT: begin
                    sr        <= {adj[18:0], 1'b0};
                    shift_cnt <= shift_cnt + 3'd1;
                    if (shift_cnt == 3'd7) state <= C_COMMIT;
                end
                C_COMMIT: begin
                    busy  <= 1'b0;
                    state <= C_IDLE;
                end
                default: state <= C_IDLE;
            endcase
        end
    end

    // Consumer captures bcd on the commit edge while done is high
    assign done = (state == C_COMMIT);
    assign bcd  = sr[19:8];

endmodule

// File: rtl/simon_msg_display.sv
// rtl/simon_msg_display.sv - Simon message/score renderer on a 4-digit 7-seg; MSG_DISPLAY_BLINK_EN blinks "Err "
module simon_msg_display
    import simon_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] msg,
    input  logic [7:0] score,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] R_TERM = RW'(REFRESH_DIV - 1);

    logic [3:0]    msg_q;
    logic [7:0]    score_q;
    logic [7:0]    score_last;
    logic [11:0]   bcd_disp;
    logic [11:0]   bcd_result;
    logic          conv_start;
    logic          conv_done;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [3:0]    an_q;

    assign conv_start = !busy && (score_q != score_last);
    assign idx_next   = idx + 2'd1;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (score_q),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (bcd_result)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            msg_q      <= '0;
            score_q    <= '0;
            score_last <= '0;
            bcd_disp   <= '0;
        end else begin
            msg_q   <= msg;
            score_q <= score;
            if (conv_start) score_last <= score_q;
            if (conv_done)  bcd_disp   <= bcd_result;
        end
    end

    // Four glyphs packed leftmost-first; digit d lives at bits [d*5 +: 5]
    function automatic glyph_e text_glyph(input logic [3:0] m, input logic [1:0] d,
                                          input logic [11:0] b);
        logic [19:0] row;
        case (m)
            MSG_RED:   row = {GL_R, GL_E, GL_D, GL_BLANK};
            MSG_GREEN: row = {GL_G, GL_R, GL_N, GL_BLANK};
            MSG_BLUE:  row = {GL_B, GL_L, GL_U, GL_E};
            MSG_YEL:   row = {GL_Y, GL_E, GL_L, GL_BLANK};
            MSG_RDY:   row = {GL_R, GL_D, GL_Y, GL_BLANK};
            MSG_GOOD:  row = {GL_G, GL_O, GL_O, GL_D};
            MSG_ERR:   row = {GL_E, GL_R, GL_R, GL_BLANK};
            MSG_DONE:  row = {GL_D, GL_O, GL_N, GL_E};
            MSG_SCORE: row = {GL_P, digit_glyph(b[11:8]), digit_glyph(b[7:4]),
                              digit_glyph(b[3:0])};
            default:   row = {GL_DASH, GL_DASH, GL_DASH, GL_DASH};
        endcase
        return glyph_e'(row[int'(d) * 5 +: 5]);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            refresh_cnt <= '0;
            idx         <= '0;
            an_q        <= 4'hF;
            seg         <= SEG_BLANK;
        end else if (refresh_cnt == R_TERM) begin
            refresh_cnt <= '0;
            idx         <= idx_next;
            an_q        <= ~(4'b0001 << idx_next);
            seg         <= glyph_seg(text_glyph(msg_q, idx_next, bcd_disp));
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

`ifdef MSG_DISPLAY_BLINK_EN
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] B_TERM = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          phase;

    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == B_TERM) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Only the anodes are gated so the scan stays in step across the dark phase
    assign an = (msg_q == MSG_ERR && phase) ? 4'hF : an_q;
`else
    assign an = an_q;
`endif

endmodule

// File: tb/tb_simon_msg_display.sv
// tb/tb_simon_msg_display.sv - directed self-checking bench for simon_msg_display
module tb_simon_msg_display;

    logic       clk;
    logic       reset;
    logic [3:0] msg;
    logic [7:0] score;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    simon_msg_display #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk   (clk),
        .reset (reset),
        .msg   (msg),
        .score (score),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records the glyph written on each anode update; only fresh updates count
    task automatic frame(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                         input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] s [4];
        logic [3:0] seen;
        logic [3:0] prev;
        int blanks;
        seen   = 4'h0;
        blanks = 0;
        prev   = an;
        for (int i = 0; i < 4; i++) s[i] = 7'hxx;
        for (int c = 0; c < 24 && seen != 4'hF; c++) begin
            tick(1);
            if (an == 4'hF) blanks++;
            if (an != prev) begin
                case (an)
                    4'hE: begin s[0] = seg; seen[0] = 1'b1; end
                    4'hD: begin s[1] = seg; seen[1] = 1'b1; end
                    4'hB: begin s[2] = seg; seen[2] = 1'b1; end
                    4'h7: begin s[3] = seg; seen[3] = 1'b1; end
                    default: ;
                endcase
            end
            prev = an;
        end
        check({tag, "_all_digits"}, {28'd0, seen}, 32'hF);
        check({tag, "_no_blank"}, blanks, 0);
        check({tag, "_d3"}, {25'd0, s[3]}, {25'd0, e3});
        check({tag, "_d2"}, {25'd0, s[2]}, {25'd0, e2});
        check({tag, "_d1"}, {25'd0, s[1]}, {25'd0, e1});
        check({tag, "_d0"}, {25'd0, s[0]}, {25'd0, e0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] an_seq [4];
        int cnt;
        an_seq = '{4'hB, 4'h7, 4'hE, 4'hD};

        reset = 1'b0;
        msg   = 4'd9;
        score = 8'd0;
        tick(3);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_busy", {31'd0, busy}, 0);

        reset = 1'b1;
        tick(3);
        check("scan_pre_first", {28'd0, an}, 32'hF);
        tick(1);
        check("scan_first_an", {28'd0, an}, 32'hD);
        check("scan_first_seg", {25'd0, seg}, 32'h3F);
        for (int k = 0; k < 4; k++) begin
            tick(4);
            check("scan_an", {28'd0, an}, {28'd0, an_seq[k]});
            check("scan_seg", {25'd0, seg}, 32'h3F);
        end

        msg   = 4'd8;
        score = 8'd255;
        tick(1);
        check("conv_e1_busy", {31'd0, busy}, 0);
        tick(1);
        check("conv_e2_busy", {31'd0, busy}, 1);
        tick(8);
        check("conv_e10_busy", {31'd0, busy}, 1);
        tick(1);
        check("conv_e11_busy", {31'd0, busy}, 0);
        check("conv_e11_bcd", {20'd0, dut.bcd_disp}, 32'h255);
        frame("p255", 7'h0C, 7'h24, 7'h12, 7'h12);

        score = 8'd0;
        tick(13);
        check("conv_zero_bcd", {20'd0, dut.bcd_disp}, 32'h0);
        score = 8'd255;
        tick(3);
        score = 8'd7;
        tick(1);
        tick(7);
        check("mid_e11_busy", {31'd0, busy}, 0);
        check("mid_e11_bcd", {20'd0, dut.bcd_disp}, 32'h255);
        tick(1);
        check("mid_e12_busy", {31'd0, busy}, 1);
        tick(8);
        check("mid_e20_busy", {31'd0, busy}, 1);
        check("mid_e20_bcd", {20'd0, dut.bcd_disp}, 32'h255);
        tick(1);
        check("mid_e21_busy", {31'd0, busy}, 0);
        check("mid_e21_bcd", {20'd0, dut.bcd_disp}, 32'h007);
        frame("p007", 7'h0C, 7'h40, 7'h40, 7'h78);

        msg = 4'd5;
        tick(1);
        frame("good", 7'h42, 7'h23, 7'h23, 7'h21);
        msg = 4'd0;
        tick(1);
        frame("red", 7'h2F, 7'h06, 7'h21, 7'h7F);

        msg = 4'd6;
        tick(1);
        cnt = 0;
        for (int c = 0; c < 32; c++) begin
            tick(1);
            if (an == 4'hF) cnt++;
        end
`ifdef MSG_DISPLAY_BLINK_EN
        check("blink_dark_cycles", cnt, 16);
`else
        check("steady_dark_cycles", cnt, 0);
`endif

        msg   = 4'd8;
        score = 8'd200;
        tick(2);
        check("rsh_e2_busy", {31'd0, busy}, 1);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rsh_busy", {31'd0, busy}, 0);
        check("rsh_bcd", {20'd0, dut.bcd_disp}, 32'h0);
        check("rsh_an", {28'd0, an}, 32'hF);
        check("rsh_seg", {25'd0, seg}, 32'h7F);
        tick(1);
        reset = 1'b1;
        tick(2);
        check("rel_busy", {31'd0, busy}, 1);
        tick(9);
        check("rel_done_busy", {31'd0, busy}, 0);
        check("rel_bcd", {20'd0, dut.bcd_disp}, 32'h200);
        frame("p200", 7'h0C, 7'h24, 7'h40, 7'h40);

        score = 8'd0;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (busy) cnt++;
        end
        check("zero_no_conv", cnt, 0);
        check("zero_bcd", {20'd0, dut.bcd_disp}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
